instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the fetch stage: accepts one decoded Y86-64 instruction (icode, ifun, rA, rB, valC) and serialises it, one byte per cycle, into instruction memory over a byte-wide write port.
- Tracks the running write PC, so a stream of instructions is laid out contiguously the way fetch will later read it.
- Used by program loaders and by fetch/decode self-check benches.

Parameters:
- ADDR_W, 64, width of write address and PC.
- RESET_PC, 64'h0, write pointer value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  request to overwrite the write pointer with load_addr.
- load_addr  in  ADDR_W  new write pointer value.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept an instruction this cycle.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- rA  in  4  register A specifier.
- rB  in  4  register B specifier.
- valC  in  64  constant word.
- mem_we  out  1  byte write strobe.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte data.
- busy  out  1  emitting bytes.
- done  out  1  one-cycle pulse: instruction fully written.
- err  out  1  one-cycle pulse: invalid icode rejected.
- next_pc  out  ADDR_W  current write pointer, i.e. address of the next instruction.

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active-low.
- Reset values: state=IDLE, next_pc=RESET_PC; mem_we, busy, done and err all 0; mem_addr=0; mem_wdata=0.
- States:
  - IDLE: in_ready = !load_valid. busy=0.
  - EMIT: in_ready=0. busy=1.
- Load: in IDLE with load_valid=1, next_pc <= load_addr on that edge. load_valid is ignored in EMIT. Load has priority over in_valid in the same cycle, and in_ready=0 that cycle.
- Accept: on in_valid && in_ready, latch all fields and set base=next_pc.
- Length by icode:
  - 1 byte: 0 halt, 1 nop, 9 ret.
  - 2 bytes: 2 rrmovq/cmovXX, 6 OPq, A pushq, B popq.
  - 10 bytes: 3 irmovq, 4 rmmovq, 5 mrmovq.
  - 9 bytes: 7 jXX, 8 call.
  - C..F: invalid.
- Invalid icode: err=1 in the cycle after accept; no write; next_pc unchanged; stay IDLE.
- Byte image:
  - byte0 = {icode, ifun}.
  - Lengths 2/10: byte1 = {rA, rB}; valC little-endian in bytes 2..9.
  - Length 9: valC little-endian in bytes 1..8.
  - Fields are written as given; no checking of the 0xF register convention or of ifun.
- EMIT, starting the cycle after accept:
  - mem_we=1, mem_addr = base + idx (mod 2^ADDR_W), mem_wdata = byte[idx], with idx starting at 0.
  - The byte is consumed on an edge where mem_ready=1: idx increments.
  - With mem_ready=0, mem_we, mem_addr and mem_wdata hold stable.
- Completion: on the edge consuming the last byte, next state is IDLE, next_pc <= base + len (wraps mod 2^ADDR_W), and done=1 for the following cycle.
- Latency: with mem_ready held high, an instruction accepted at cycle T writes during T+1..T+len. done and the updated next_pc are visible at T+len+1, when in_ready is high again.
- Back-to-back: a new instruction may be accepted in the same cycle done is high.
- in_valid is ignored while busy; fields need not be held after accept.
- Reset mid-EMIT: all writes abort immediately; outputs return to reset values; next_pc=RESET_PC.

Test Plan:
1. Reset: rst_n=0 mid-cycle, all outputs take reset values asynchronously. Release, then accept halt (0x00) -> single write addr 0 data 0x00; done; next_pc=1.
2. load 0x10, then irmovq icode 3, ifun 0, rA F, rB 3, valC 0x0123456789ABCDEF -> writes at 0x10..0x19: 30 F3 EF CD AB 89 67 45 23 01; next_pc=0x1A.
3. jXX icode 7, ifun 3, valC 0x40 at PC 0x1A -> 9 writes: 73 40 00 00 00 00 00 00 00; next_pc=0x23. Then OPq 0x60 rA 2 rB 3 accepted in the done cycle -> writes 60 23; next_pc=0x25.
4. Backpressure: rmmovq with mem_ready low for 3 cycles on byte 4 -> mem_addr and mem_wdata held; exactly 10 writes; no byte duplicated or skipped.
5. Invalid icode 0xC -> err pulse one cycle; mem_we never asserted; next_pc unchanged. load_valid together with in_valid in IDLE -> load wins; in_ready=0.
6. Wrap: load 0xFFFFFFFFFFFFFFFF, then pushq 0xA0 rA 3 rB F -> writes A0 at 0xFF..FF and 3F at 0x0; next_pc=1. Reset asserted at byte 5 of a 10-byte emit -> writes stop, next_pc=RESET_PC.

Source files
------------

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Serialises one decoded Y86-64 instruction into a byte-wide
//            instruction-memory write port, one byte per accepted cycle, and
//            tracks the running write PC so successive instructions land
//            contiguously.
// Revision : 1.0  initial release
// ============================================================================
module instr_encoder #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] next_pc
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [79:0]       img_q, img_d;
    logic [3:0]        rem_q, rem_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [3:0]        len;
    logic [79:0]       img_new;

    // Instruction length and byte image (byte0 in the low bits); len=0 marks an invalid icode.
    always_comb begin
        len     = 4'd0;
        img_new = 80'd0;
        case (icode)
            4'h0, 4'h1, 4'h9: begin
                len     = 4'd1;
                img_new = {72'd0, icode, ifun};
            end
            4'h2, 4'h6, 4'hA, 4'hB: begin
                len     = 4'd2;
                img_new = {64'd0, rA, rB, icode, ifun};
            end
            4'h3, 4'h4, 4'h5: begin
                len     = 4'd10;
                img_new = {valC, rA, rB, icode, ifun};
            end
            4'h7, 4'h8: begin
                len     = 4'd9;
                img_new = {8'd0, valC, icode, ifun};
            end
            default: begin
                len     = 4'd0;
                img_new = 80'd0;
            end
        endcase
    end

    // Next-state logic: load/accept in IDLE, byte-by-byte drain in EMIT.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        img_d   = img_q;
        rem_d   = rem_q;
        we_d    = we_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    pc_d = load_addr;
                end else if (in_valid) begin
                    if (len != 4'd0) begin
                        state_d = ST_EMIT;
                        we_d    = 1'b1;
                        addr_d  = pc_q;
                        img_d   = img_new;
                        rem_d   = len - 4'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (mem_ready) begin
                    // Shift the image so the next byte sits at the output; zero-fill behind it.
                    img_d = {8'd0, img_q[79:8]};
                    if (rem_q == 4'd0) begin
                        state_d = ST_IDLE;
                        we_d    = 1'b0;
                        pc_d    = addr_q + ADDR_ONE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d  = rem_q - 4'd1;
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any emit in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= {ADDR_W{1'b0}};
            img_q   <= 80'd0;
            rem_q   <= 4'd0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            img_q   <= img_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !load_valid;
    assign busy      = (state_q == ST_EMIT);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = img_q[7:0];
    assign done      = done_q;
    assign err       = err_q;
    assign next_pc   = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Directed self-checking bench for instr_encoder.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [63:0] load_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic        mem_we;
    logic        mem_ready;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy, done, err;
    logic [63:0] next_pc;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    logic [7:0]  exp_b[$];

    instr_encoder #(.ADDR_W(64), .RESET_PC(64'h0)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .icode      (icode),
        .ifun       (ifun),
        .rA         (rA),
        .rB         (rB),
        .valC       (valC),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .next_pc    (next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record each byte the memory accepts (write strobe with ready high).
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_writes(input string tag, input logic [63:0] base);
        check({tag, " count"}, 64'(wr_addr.size()), 64'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < wr_addr.size(); i++) begin
            check($sformatf("%s addr%0d", tag, i), wr_addr[i], base + 64'(i));
            check($sformatf("%s data%0d", tag, i), 64'(wr_data[i]), 64'(exp_b[i]));
        end
    endtask

    task automatic do_load(input logic [63:0] a);
        load_valid = 1'b1;
        load_addr  = a;
        tick();
        load_valid = 1'b0;
        check("load next_pc", next_pc, a);
    endtask

    // Issue one instruction; optionally stall 3 cycles when byte stall_at is presented.
    task automatic run_instr(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                             input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                             input logic [63:0] base, input logic [63:0] exp_pc,
                             input int stall_at, input int exp_cyc);
        int n;
        int stalls;
        stalls = (stall_at >= 0) ? 3 : 0;
        clear_log();
        icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        icode = 4'h0; ifun = 4'h0; rA = 4'h0; rB = 4'h0; valC = 64'h0;
        n = 1;
        while (done !== 1'b1 && n < 60) begin
            if (stall_at >= 0 && wr_addr.size() == stall_at) begin
                check({tag, " hold we"},   64'(mem_we), 64'd1);
                check({tag, " hold addr"}, mem_addr, base + 64'(stall_at));
                check({tag, " hold data"}, 64'(mem_wdata), 64'(exp_b[stall_at]));
            end
            if (stalls > 0 && wr_addr.size() == stall_at) begin
                mem_ready = 1'b0;
                stalls--;
            end else begin
                mem_ready = 1'b1;
            end
            tick();
            n++;
        end
        mem_ready = 1'b1;
        check({tag, " done"}, 64'(done), 64'd1);
        if (exp_cyc > 0) check({tag, " latency"}, 64'(n), 64'(exp_cyc));
        check({tag, " next_pc"}, next_pc, exp_pc);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        check_writes(tag, base);
    endtask

    initial begin
        int n;
        rst_n = 1'b1; load_valid = 1'b0; load_addr = 64'h0; in_valid = 1'b0;
        icode = 4'h0; ifun = 4'h0; rA = 4'h0; rB = 4'h0; valC = 64'h0;
        mem_ready = 1'b1;

        // 1. asynchronous reset before any clock edge
        #3 rst_n = 1'b0;
        #1;
        check("rst mem_we",    64'(mem_we), 64'd0);
        check("rst busy",      64'(busy), 64'd0);
        check("rst done",      64'(done), 64'd0);
        check("rst err",       64'(err), 64'd0);
        check("rst mem_addr",  mem_addr, 64'h0);
        check("rst mem_wdata", 64'(mem_wdata), 64'h0);
        check("rst next_pc",   next_pc, 64'h0);
        check("rst in_ready",  64'(in_ready), 64'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        exp_b = '{8'h00};
        run_instr("halt", 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 64'h1, -1, 2);
        tick();
        check("done pulse", 64'(done), 64'd0);

        // 2. load then irmovq
        do_load(64'h10);
        exp_b = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        run_instr("irmovq", 4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'h10, 64'h1A, -1, 11);

        // 3. jXX then OPq accepted in the done cycle
        tick();
        exp_b = '{8'h73, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_instr("jxx", 4'h7, 4'h3, 4'h0, 4'h0, 64'h40, 64'h1A, 64'h23, -1, 10);
        exp_b = '{8'h60, 8'h23};
        run_instr("opq", 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h23, 64'h25, -1, 3);

        // 4. rmmovq with backpressure on byte 4
        exp_b = '{8'h40, 8'h12, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        run_instr("rmmovq", 4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788, 64'h25, 64'h2F, 4, 14);

        // 5. invalid icode
        tick();
        clear_log();
        icode = 4'hC; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; icode = 4'h0;
        check("inv err",    64'(err), 64'd1);
        check("inv mem_we", 64'(mem_we), 64'd0);
        check("inv busy",   64'(busy), 64'd0);
        tick();
        check("inv err pulse", 64'(err), 64'd0);
        check("inv writes",    64'(wr_addr.size()), 64'd0);
        check("inv next_pc",   next_pc, 64'h2F);

        // load beats in_valid in the same cycle
        load_valid = 1'b1; load_addr = 64'h100; in_valid = 1'b1; icode = 4'h1;
        #1;
        check("ld+in in_ready", 64'(in_ready), 64'd0);
        tick();
        load_valid = 1'b0; in_valid = 1'b0; icode = 4'h0;
        check("ld+in next_pc", next_pc, 64'h100);
        check("ld+in busy",    64'(busy), 64'd0);
        tick();
        check("ld+in mem_we",  64'(mem_we), 64'd0);
        check("ld+in writes",  64'(wr_addr.size()), 64'd0);

        // 6. address wrap
        do_load(64'hFFFFFFFFFFFFFFFF);
        exp_b = '{8'hA0, 8'h3F};
        run_instr("pushq", 4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h1, -1, 3);

        // reset in the middle of a 10-byte emit
        tick();
        clear_log();
        icode = 4'h5; ifun = 4'h0; rA = 4'h1; rB = 4'h2; valC = 64'h0807060504030201;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (wr_addr.size() < 5 && n < 40) begin
            tick();
            n++;
        end
        exp_b = '{8'h50, 8'h12, 8'h01, 8'h02, 8'h03};
        check_writes("mrmovq pre", 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst mem_we",    64'(mem_we), 64'd0);
        check("mid rst busy",      64'(busy), 64'd0);
        check("mid rst next_pc",   next_pc, 64'h0);
        check("mid rst mem_addr",  mem_addr, 64'h0);
        check("mid rst mem_wdata", 64'(mem_wdata), 64'h0);
        tick();
        tick();
        check("mid rst writes", 64'(wr_addr.size()), 64'd5);
        rst_n = 1'b1;
        tick();
        check("post rst in_ready", 64'(in_ready), 64'd1);
        check("post rst mem_we",   64'(mem_we), 64'd0);
        check("post rst next_pc",  next_pc, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
